// File: rtl/micro_harness_pkg.sv
// Shared types and constants for the micro tile stimulus/response harness.
package micro_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Tap masks name the bits XORed into bit 0 of a left-shifting register.
    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;    // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] MISR_TAPS    = 16'hD008; // x^16+x^15+x^13+x^4+1
    localparam logic [7:0]  DEFAULT_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/harness_misr.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
module harness_misr
    import micro_harness_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[14:0], ^(sig & MISR_TAPS)} ^ {8'h00, din};
        end
    end

endmodule

// File: rtl/micro_tile_harness.sv
// Drives a micro tile with LFSR stimulus and folds its responses into a MISR signature.
module micro_tile_harness
    import micro_harness_pkg::*;
#(
    parameter int N_VEC_W      = 8,
    parameter int RESET_CYCLES = 4,
    parameter int LATENCY      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         seed,
    input  logic [N_VEC_W-1:0] num_vectors,
    output logic [7:0]         dut_ui_in,
    input  logic [7:0]         dut_uo_out,
    output logic               dut_rst_n,
    output logic               busy,
    output logic               done,
    output logic [15:0]        signature
);

    localparam int TMR_W = 8;

    state_t             state, state_nxt;
    logic [7:0]         lfsr;
    logic [N_VEC_W-1:0] vec_cnt;
    logic [TMR_W-1:0]   tmr;
    logic               start_acc;
    logic               run_vld;
    logic               sample_vld;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign run_vld   = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DUT_RST;
            DUT_RST: if (tmr == '0) state_nxt = RUN;
            RUN:     if (vec_cnt == N_VEC_W'(1)) state_nxt = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN:   if (tmr == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = DUT_RST;
            default: state_nxt = IDLE;
        endcase
    end

    // A loaded count of 0 wraps on its first decrement, giving 2**N_VEC_W vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= DEFAULT_SEED;
            vec_cnt <= '0;
            tmr     <= '0;
        end else if (start_acc) begin
            lfsr    <= (seed == 8'h00) ? DEFAULT_SEED : seed;
            vec_cnt <= num_vectors;
            tmr     <= TMR_W'(RESET_CYCLES - 1);
        end else begin
            case (state)
                DUT_RST: tmr <= tmr - TMR_W'(1);
                RUN: begin
                    lfsr    <= lfsr_next(lfsr);
                    vec_cnt <= vec_cnt - N_VEC_W'(1);
                    tmr     <= TMR_W'(LATENCY - 1);
                end
                DRAIN:   tmr <= tmr - TMR_W'(1);
                default: ;
            endcase
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign sample_vld = run_vld;
        end else begin : g_dly
            logic [LATENCY-1:0] vld_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= (vld_sr << 1) | LATENCY'(run_vld);
                end
            end
            assign sample_vld = vld_sr[LATENCY-1];
        end
    endgenerate

    assign dut_ui_in = (state == RUN) ? lfsr : '0;
    assign dut_rst_n = state inside {RUN, DRAIN, DONE};
    assign busy      = state inside {DUT_RST, RUN, DRAIN};
    assign done      = (state == DONE);

    harness_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (sample_vld),
        .din (dut_uo_out),
        .sig (signature)
    );

endmodule

// File: tb/tb_micro_tile_harness.sv
// Directed bench: a registered tile on a LATENCY=1 harness, a combinational tile on LATENCY=0.
module tb_micro_tile_harness;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, dut_rst_n_a, busy_a, done_a;
    logic [7:0]  seed_a, nvec_a, ui_a, uo_a;
    logic [15:0] sig_a;

    logic        rst_b, start_b, dut_rst_n_b, busy_b, done_b;
    logic [7:0]  seed_b, nvec_b, ui_b, uo_b;
    logic [15:0] sig_b;

    micro_tile_harness #(.N_VEC_W(8), .RESET_CYCLES(4), .LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .seed(seed_a), .num_vectors(nvec_a),
        .dut_ui_in(ui_a), .dut_uo_out(uo_a), .dut_rst_n(dut_rst_n_a),
        .busy(busy_a), .done(done_a), .signature(sig_a)
    );

    micro_tile_harness #(.N_VEC_W(8), .RESET_CYCLES(4), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .seed(seed_b), .num_vectors(nvec_b),
        .dut_ui_in(ui_b), .dut_uo_out(uo_b), .dut_rst_n(dut_rst_n_b),
        .busy(busy_b), .done(done_b), .signature(sig_b)
    );

    // Tile models: A registers ui once, B is combinational.
    always @(posedge clk) uo_a <= dut_rst_n_a ? ui_a : 8'h00;
    assign uo_b = ui_b ^ 8'hA5;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_sig(input logic [7:0] sd, input int n, input logic [7:0] mask);
        logic [7:0]  l;
        logic [15:0] s;
        l = (sd == 8'h00) ? 8'h01 : sd;
        s = 16'h0000;
        for (int k = 0; k < n; k++) begin
            s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, l ^ mask};
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return s;
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  seed;
        logic [7:0]  nvec;
        int          poke;
        logic [7:0]  exp_v0;
        int          exp_nvec;
        int          exp_busy;
        logic [15:0] exp_sig;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] vecs[$];
    int         busy_n, first_i, last_i;
    logic       got_done;

    task automatic run_a(input logic [7:0] sd, input logic [7:0] n, input int poke);
        vecs.delete();
        busy_n   = 0;
        first_i  = -1;
        last_i   = -1;
        got_done = 1'b0;
        @(negedge clk);
        seed_a  = sd;
        nvec_a  = n;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("entry_done_low", {31'd0, done_a}, 32'd0);
        check("entry_sig_clear", {16'd0, sig_a}, 32'd0);
        for (int i = 0; i < 2000; i++) begin
            if (done_a) begin
                got_done = 1'b1;
                break;
            end
            if (busy_a) busy_n++;
            if (ui_a != 8'h00) begin
                vecs.push_back(ui_a);
                if (first_i < 0) first_i = i;
                last_i = i;
            end
            start_a = (i == poke);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    initial begin
        logic quiet;
        logic [15:0] exp_b;

        rst_a = 1'b1; start_a = 1'b0; seed_a = 8'h00; nvec_a = 8'h00;
        rst_b = 1'b1; start_b = 1'b0; seed_b = 8'h00; nvec_b = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_dut_rst_n", {31'd0, dut_rst_n_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_signature", {16'd0, sig_a}, 32'h0000);
        check("rst_ui_in", {24'd0, ui_a}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        tbl[0] = '{"s01_n3",   8'h01, 8'd3, -1, 8'h01, 3, 8, 16'h0004};
        tbl[1] = '{"s00_n3",   8'h00, 8'd3, -1, 8'h01, 3, 8, 16'h0004};
        tbl[2] = '{"poke_run", 8'h01, 8'd3,  5, 8'h01, 3, 8, 16'h0004};
        tbl[3] = '{"s80_n2",   8'h80, 8'd2, -1, 8'h80, 2, 7, 16'h0101};
        tbl[4] = '{"s01_n1",   8'h01, 8'd1, -1, 8'h01, 1, 6, 16'h0001};
        tbl[5] = '{"s5a_n2",   8'h5A, 8'd2, -1, 8'h5A, 2, 7, 16'h0001};

        for (int t = 0; t < 6; t++) begin
            run_a(tbl[t].seed, tbl[t].nvec, tbl[t].poke);
            check({tbl[t].name, "_done"}, {31'd0, got_done}, 32'd1);
            check({tbl[t].name, "_nvec"}, vecs.size(), tbl[t].exp_nvec);
            check({tbl[t].name, "_v0"}, (vecs.size() > 0) ? {24'd0, vecs[0]} : 32'hFFFF, {24'd0, tbl[t].exp_v0});
            check({tbl[t].name, "_contig"}, last_i - first_i + 1, tbl[t].exp_nvec);
            check({tbl[t].name, "_busy"}, busy_n, tbl[t].exp_busy);
            check({tbl[t].name, "_sig"}, {16'd0, sig_a}, {16'd0, tbl[t].exp_sig});
            if (t == 0) begin
                check("s01_n3_v1", (vecs.size() > 1) ? {24'd0, vecs[1]} : 32'hFFFF, 32'h02);
                check("s01_n3_v2", (vecs.size() > 2) ? {24'd0, vecs[2]} : 32'hFFFF, 32'h04);
            end
        end

        // Reset in the middle of a long run.
        @(negedge clk);
        seed_a = 8'h01; nvec_a = 8'd50; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_active", {31'd0, dut_rst_n_a}, 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("midrst_dut_rst_n", {31'd0, dut_rst_n_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_done", {31'd0, done_a}, 32'd0);
        check("midrst_sig", {16'd0, sig_a}, 32'd0);
        check("midrst_ui", {24'd0, ui_a}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ui_a != 8'h00 || done_a || busy_a) quiet = 1'b0;
        end
        check("midrst_quiet", {31'd0, quiet}, 32'd1);

        // Full 256-vector run on the combinational tile.
        vecs.delete();
        busy_n   = 0;
        got_done = 1'b0;
        @(negedge clk);
        seed_b = 8'h5A; nvec_b = 8'd0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_b) begin
                got_done = 1'b1;
                break;
            end
            if (busy_b) busy_n++;
            if (busy_b && dut_rst_n_b) vecs.push_back(ui_b);
            @(negedge clk);
        end
        exp_b = ref_sig(8'h5A, 256, 8'hA5);
        check("b_done", {31'd0, got_done}, 32'd1);
        check("b_nvec", vecs.size(), 256);
        check("b_busy", busy_n, 260);
        check("b_v0", (vecs.size() > 0) ? {24'd0, vecs[0]} : 32'hFFFF, 32'h5A);
        check("b_v256_eq_v1", (vecs.size() > 255) ? {24'd0, vecs[255]} : 32'hFFFF, 32'h5A);
        check("b_sig", {16'd0, sig_b}, {16'd0, exp_b});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
